// File: rtl/enc_dec_pkg.sv
// ============================================================================
// Module : enc_dec_pkg
// Brief  : Shared types and helpers for the 32-bit extended-Hamming (SECDED) codec.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package enc_dec_pkg;

   localparam int PARITY_BITS = 5;
   localparam int CODE_WIDTH  = 2 ** PARITY_BITS;
   localparam int DATA_WIDTH  = CODE_WIDTH - PARITY_BITS - 1;

   typedef logic [CODE_WIDTH-1:0]  codeword_t;
   typedef logic [DATA_WIDTH-1:0]  data_t;
   typedef logic [PARITY_BITS-1:0] col_t;

   // Position 0 (overall parity) and powers of two carry no payload.
   function automatic logic is_parity_pos(input col_t c);
      return ((c & (c - 1'b1)) == '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_encode_32.sv
// ============================================================================
// Module : hamming_encode_32
// Brief  : Pure combinational SECDED encoder, payload -> 32-bit codeword.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hamming_encode_32
   import enc_dec_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [CODE_WIDTH-1:0] code_o
);

   always_comb begin : p_encode
      codeword_t cw;
      int        di;
      logic      p;
      cw = '0;
      di = 0;
      p  = 1'b0;
      for (int k = 1; k < CODE_WIDTH; k++) begin
         if (!is_parity_pos(col_t'(k))) begin
            cw[k] = data_i[di];
            di    = di + 1;
         end
      end
      // Parity slots are still zero here, so each covers only payload bits.
      for (int i = 0; i < PARITY_BITS; i++) begin
         p = 1'b0;
         for (int k = 1; k < CODE_WIDTH; k++) begin
            if (((k >> i) & 1) == 1) begin
               p = p ^ cw[k];
            end
         end
         cw[1 << i] = p;
      end
      cw[0]  = ^cw[CODE_WIDTH-1:1];
      code_o = cw;
   end

endmodule

`default_nettype wire

// File: rtl/enc_output_ctrl.sv
// ============================================================================
// Module : enc_output_ctrl
// Brief  : Two-stage valid/ready SECDED encoder with 1/2-bit error injection and counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module enc_output_ctrl
   import enc_dec_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   inject_en,
   input  logic                   inject_double,
   input  logic [PARITY_BITS-1:0] inject_col1,
   input  logic [PARITY_BITS-1:0] inject_col2,
   output logic [CODE_WIDTH-1:0]  codeword,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_WIDTH-1:0]   cnt_words,
   output logic [CNT_WIDTH-1:0]   cnt_injected
);

   logic            s1_valid_q;
   data_t           s1_data_q;
   logic            s1_inj_q;
   logic            s1_dbl_q;
   col_t            s1_col1_q;
   col_t            s1_col2_q;

   logic            out_valid_q;
   codeword_t       codeword_q;
   codeword_t       codeword_d;
   logic            s2_inj_q;
   logic [CNT_WIDTH-1:0] cnt_words_q;
   logic [CNT_WIDTH-1:0] cnt_words_d;
   logic [CNT_WIDTH-1:0] cnt_inj_q;
   logic [CNT_WIDTH-1:0] cnt_inj_d;

   codeword_t       w_enc;
   codeword_t       w_mask;
   logic            w_move;
   logic            w_in_xfer;
   logic            w_out_xfer;

   hamming_encode_32 u_encode (
      .data_i (s1_data_q),
      .code_o (w_enc)
   );

   assign w_move     = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready   = ~s1_valid_q | ~out_valid_q | out_ready;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid_q & out_ready;

   // ORing the two one-hot flips makes col1==col2 a single flip, never a cancellation.
   always_comb begin
      w_mask = '0;
      if (s1_inj_q) begin
         w_mask[s1_col1_q] = 1'b1;
         if (s1_dbl_q) begin
            w_mask[s1_col2_q] = 1'b1;
         end
      end
   end

   always_comb begin
      codeword_d  = w_enc ^ w_mask;
      cnt_words_d = cnt_words_q;
      cnt_inj_d   = cnt_inj_q;
      if (w_out_xfer && (cnt_words_q != '1)) begin
         cnt_words_d = cnt_words_q + 1'b1;
      end
      if (w_out_xfer && s2_inj_q && (cnt_inj_q != '1)) begin
         cnt_inj_d = cnt_inj_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_inj_q    <= 1'b0;
         s1_dbl_q    <= 1'b0;
         s1_col1_q   <= '0;
         s1_col2_q   <= '0;
         out_valid_q <= 1'b0;
         codeword_q  <= '0;
         s2_inj_q    <= 1'b0;
         cnt_words_q <= '0;
         cnt_inj_q   <= '0;
      end else begin
         if (w_in_xfer) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= data_in;
            s1_inj_q   <= inject_en;
            s1_dbl_q   <= inject_en & inject_double;
            // Columns are only meaningful with inject_en; keep X out of the register.
            s1_col1_q  <= inject_en ? inject_col1 : '0;
            s1_col2_q  <= inject_en ? inject_col2 : '0;
         end else if (w_move) begin
            s1_valid_q <= 1'b0;
         end

         if (w_move) begin
            out_valid_q <= 1'b1;
            codeword_q  <= codeword_d;
            s2_inj_q    <= s1_inj_q;
         end else if (w_out_xfer) begin
            out_valid_q <= 1'b0;
         end

         cnt_words_q <= cnt_words_d;
         cnt_inj_q   <= cnt_inj_d;
      end
   end

   assign codeword     = codeword_q;
   assign out_valid    = out_valid_q;
   assign cnt_words    = cnt_words_q;
   assign cnt_injected = cnt_inj_q;

endmodule

`default_nettype wire
